// File: rtl/rv32i_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_mem_pkg
// Shared types and helpers for the RV32I data memory slice.
//   XLEN          : data path width (32)
//   mem_funct3_e  : load/store width encodings taken from the RV32I funct3 field
//   mem_state_e   : data_memory control states (CLEAR sweep, READY for traffic)
//   sext_byte/half: sign-extension helpers used by the load path
// -----------------------------------------------------------------------------
package rv32i_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    function automatic logic [XLEN-1:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext_half(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
// Purely combinational lane steering for the RV32I data memory.
//   funct3     in  3   access width / signedness
//   write      in  1   1 = store, 0 = load
//   addr_lo    in  2   byte offset inside the word
//   wdata      in  32  LSB-aligned store data
//   raw_word   in  32  word currently held in the RAM at the target index
//   byte_en    out 4   lanes to update on a store
//   store_data out 32  store data replicated onto every lane
//   load_data  out 32  selected lane(s), sign or zero extended
//   misaligned out 1   H/HU on an odd address, W not on a word boundary
//   illegal    out 1   reserved funct3, or BU/HU used as a store
// Byte enables and store data are produced regardless of the error flags;
// the caller gates the write with them.
// -----------------------------------------------------------------------------
module load_store_align
    import rv32i_mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic            write,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] raw_word,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] shifted_s;

    // Decode funct3 into lane enables, replicated store data and extended load data.
    always_comb begin
        // Bring the addressed lane down to bit 0 so byte/half selection is uniform.
        shifted_s  = raw_word >> {addr_lo, 3'b000};
        byte_en    = 4'b0000;
        store_data = {XLEN{1'b0}};
        load_data  = {XLEN{1'b0}};
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            MEM_B: begin
                byte_en    = 4'b0001 << addr_lo;
                store_data = {4{wdata[7:0]}};
                load_data  = sext_byte(shifted_s[7:0]);
            end
            MEM_BU: begin
                illegal    = write;
                load_data  = {24'h000000, shifted_s[7:0]};
            end
            MEM_H: begin
                misaligned = addr_lo[0];
                if (addr_lo[1]) begin
                    byte_en = 4'b1100;
                end else begin
                    byte_en = 4'b0011;
                end
                store_data = {2{wdata[15:0]}};
                load_data  = sext_half(shifted_s[15:0]);
            end
            MEM_HU: begin
                misaligned = addr_lo[0];
                illegal    = write;
                load_data  = {16'h0000, shifted_s[15:0]};
            end
            MEM_W: begin
                misaligned = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                store_data = wdata;
                load_data  = raw_word;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised RV32I data RAM with a valid/ready request port and a
// registered one-cycle response. After reset an optional sweep zeroes every
// word before requests are accepted.
//   WORDS          number of 32-bit words (>= 2)
//   CLEAR_ON_RESET 1 = zero all words after reset, 0 = keep contents
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_write      1 = store, 0 = load
//   req_funct3     RV32I width encoding (B, H, W, BU, HU)
//   req_addr       byte address; word index is req_addr[31:2]
//   req_wdata      LSB-aligned store data
//   rsp_valid      pulse one cycle after an accepted request
//   rsp_rdata      extended load data, 0 for stores and errors
//   rsp_error      misaligned, out-of-range or illegal request
//   busy           clear sweep in progress
// -----------------------------------------------------------------------------
module data_memory
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned WORDS          = 64,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    output logic            busy
);

    localparam int CW = $clog2(WORDS);

    mem_state_e      state_r;
    mem_state_e      state_next_s;
    logic [CW-1:0]   clr_cnt_r;
    logic [XLEN-1:0] mem_r [WORDS];

    logic            ready_s;
    logic            busy_s;
    logic            accept_s;
    logic [CW-1:0]   word_idx_s;
    logic            out_of_range_s;
    logic            error_s;
    logic            wr_en_s;
    logic [XLEN-1:0] rd_word_s;
    logic [3:0]      byte_en_s;
    logic [XLEN-1:0] store_data_s;
    logic [XLEN-1:0] load_data_s;
    logic            misaligned_s;
    logic            illegal_s;

    logic            rsp_valid_r;
    logic [XLEN-1:0] rsp_rdata_r;
    logic            rsp_error_r;

    // Request decode: the full 30-bit index is compared so high addresses never alias.
    assign word_idx_s     = req_addr[CW+1:2];
    assign out_of_range_s = (req_addr[XLEN-1:2] >= 30'(WORDS));
    assign accept_s       = req_valid & ready_s;
    assign error_s        = misaligned_s | illegal_s | out_of_range_s;
    assign wr_en_s        = accept_s & req_write & ~error_s;
    assign rd_word_s      = mem_r[word_idx_s];

    load_store_align u_align (
        .funct3     (req_funct3),
        .write      (req_write),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .raw_word   (rd_word_s),
        .byte_en    (byte_en_s),
        .store_data (store_data_s),
        .load_data  (load_data_s),
        .misaligned (misaligned_s),
        .illegal    (illegal_s)
    );

    // State register and clear counter; the counter only runs during the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == CLEAR) begin
                if (clr_cnt_r == CW'(WORDS - 1)) begin
                    clr_cnt_r <= {CW{1'b0}};
                end else begin
                    clr_cnt_r <= clr_cnt_r + CW'(1);
                end
            end else begin
                clr_cnt_r <= {CW{1'b0}};
            end
        end
    end

    // Next-state logic: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == CW'(WORDS - 1)) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            READY: begin
                state_next_s = READY;
            end
            default: begin
                state_next_s = CLEAR;
            end
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            CLEAR: begin
                ready_s = 1'b0;
                busy_s  = 1'b1;
            end
            READY: begin
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b1;
            end
        endcase
    end

    // RAM write port: sweep zeroing or byte-masked store; nothing is written while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // hold contents
        end else if (state_r == CLEAR) begin
            mem_r[clr_cnt_r] <= {XLEN{1'b0}};
        end else if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= store_data_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers: one pulse per accepted request, data only for good loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_error_r <= 1'b0;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_error_r <= accept_s & error_s;
            if (accept_s && !req_write && !error_s) begin
                rsp_rdata_r <= load_data_s;
            end else begin
                rsp_rdata_r <= {XLEN{1'b0}};
            end
        end
    end

    assign req_ready = ready_s;
    assign busy      = busy_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised RV32I data memory for the load/store path: a word-organised RAM with byte/halfword/word access, sign/zero extension, alignment and range checking, and a valid/ready request port with a registered response. After reset it runs a hardware clear sweep so software sees zeroed memory without a reset-time write port. It is the successor of the plain word memory and sits behind the core's memory stage.

## Interface
- WORDS, 64, number of 32-bit words; any value ≥ 2
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the sweep and retain contents
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse, response for the request accepted on the previous edge
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  request rejected (misaligned, out of range, illegal funct3)
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR, READY. Reset → CLEAR if CLEAR_ON_RESET, else READY.
- CLEAR: clear counter writes 0 to word[cnt], cnt increments each cycle; after word WORDS-1 → READY. req_ready=0, busy=1; requests are not accepted.
- READY: req_ready=1, busy=0; one request accepted per cycle.
- Word index = req_addr[31:2]; out of range when index ≥ WORDS (full 30-bit compare, no wrap).
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Illegal: funct3 011/110/111; 100/101 with req_write=1.
- Any error → memory unmodified, rsp_error=1, rsp_rdata=0.
- Store byte enables: B → 1 lane at addr[1:0]; H → lanes {addr[1],0} and {addr[1],1}; W → all 4; unselected bytes unchanged.
- Load: select lane(s) by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
- Load following a store to the same word in the next cycle returns the newly written data (write is complete before the next read).

## Timing
- Reset values: req_ready = !CLEAR_ON_RESET, busy = CLEAR_ON_RESET, rsp_valid=0, rsp_rdata=0, rsp_error=0, clear counter 0.
- Clear duration: exactly WORDS rising edges after rst deasserts; req_ready rises after the WORDS-th edge.
- Latency: request accepted at edge N → rsp_valid/rsp_rdata/rsp_error valid after edge N, sampled at edge N+1; throughput 1/cycle, no backpressure on response.
- Store takes effect at the accepting edge.
- rsp_valid=0 in any cycle following an edge without acceptance; rsp_rdata/rsp_error return to 0 then.
- rst asserted mid-sweep or mid-traffic: immediate return to reset values, in-flight response dropped, sweep restarts from word 0.

## Structure
- Package rv32i_mem_pkg: funct3 enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU), state enum (CLEAR, READY), XLEN=32.
- Sub-module load_store_align: combinational; from funct3, addr[1:0], wdata and raw word produces byte enables, lane-shifted store data, extended load data and misalign/illegal flags. Top holds RAM array, FSM, clear counter and response registers.

## Test plan
- Reset with WORDS=64: busy=1 and req_ready=0 for 64 edges, then all 64 word loads (addr 0..252) → rsp_rdata=0, rsp_error=0.
- SW 0xDEADBEEF @0x10; LB @0x10 → 0xFFFFFFEF; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0x5566 @0x22; LW @0x20 → 0x5566AA44.
- LW @0x06, LH @0x03, SW @0x100 (WORDS=64), funct3=011 → rsp_error=1, rsp_rdata=0, target words unchanged.
- Back-to-back: SW 0xCAFEBABE @0x8 then LW @0x8 on consecutive edges → rsp_valid on both following cycles, second returns 0xCAFEBABE.
- Assert rst at clear word 20, release → sweep restarts, busy for full 64 edges; CLEAR_ON_RESET=0 build: req_ready=1 on the first edge after reset.
